// File: rtl/inst_fetch_queue_mw_pkg.sv
// Shared definitions for the multi-word instruction fetch queue:
// exception codes, response classification and a constant log2 helper.
package inst_fetch_queue_mw_pkg;

  // Exception code reported with each instruction beat.
  localparam logic [4:0] ADEL          = 5'h04;
  localparam logic [4:0] INVALID_EXCEP = 5'h1f;

  // Classification of an incoming cache line response.
  typedef enum logic [1:0] {
    RESP_NONE,  // no response, or an unsolicited one
    RESP_DROP,  // belongs to a group discarded by an earlier flush
    RESP_FILL   // belongs to the oldest live unanswered group
  } resp_kind_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_mw_fetch_group_ram.sv
// Fetch group storage: one write port for allocation fields (pc, count,
// meta), one write port for the returned cache line, one async read port.
module inst_fetch_queue_mw_fetch_group_ram #(
  parameter int FETCH_WIDTH = 4,
  parameter int IFQ_ENTRY   = 8,
  parameter int META_WIDTH  = 64,
  parameter int CNT_W       = 3,
  parameter int IDX_W       = 3
) (
  input  logic                      clk,
  input  logic                      alloc_en,
  input  logic [IDX_W-1:0]          alloc_idx,
  input  logic [31:0]               alloc_pc,
  input  logic [CNT_W-1:0]          alloc_cnt,
  input  logic [META_WIDTH-1:0]     alloc_meta,
  input  logic                      line_en,
  input  logic [IDX_W-1:0]          line_idx,
  input  logic [32*FETCH_WIDTH-1:0] line_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [31:0]               rd_pc,
  output logic [CNT_W-1:0]          rd_cnt,
  output logic [META_WIDTH-1:0]     rd_meta,
  output logic [32*FETCH_WIDTH-1:0] rd_line
);

  logic [31:0]               pc_mem   [IFQ_ENTRY];
  logic [CNT_W-1:0]          cnt_mem  [IFQ_ENTRY];
  logic [META_WIDTH-1:0]     meta_mem [IFQ_ENTRY];
  logic [32*FETCH_WIDTH-1:0] line_mem [IFQ_ENTRY];

  // Capture group fields when the request is issued.
  // NOTE: the storage arrays have no reset; validity lives in the top-level
  // line_vld flags, so resetting wide data would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement or block ordering.
      pc_mem[alloc_idx]   <= alloc_pc;
      cnt_mem[alloc_idx]  <= alloc_cnt;
      meta_mem[alloc_idx] <= alloc_meta;
    end
  end

  // Capture the cache line when its response arrives.
  always_ff @(posedge clk) begin
    if (line_en) begin
      line_mem[line_idx] <= line_data;
    end
  end

  assign rd_pc   = pc_mem[rd_idx];
  assign rd_cnt  = cnt_mem[rd_idx];
  assign rd_meta = meta_mem[rd_idx];
  assign rd_line = line_mem[rd_idx];

endmodule

// File: rtl/inst_fetch_queue_mw.sv
// Multi-word fetch queue between the PC generator/BPU and the I-cache.
// Issues one line-aligned request per fetch group, matches in-order line
// responses to groups, and streams one instruction per cycle to decode.
// After a flush, responses still owed by the cache are counted as stale
// and dropped as they arrive.
module inst_fetch_queue_mw
  import inst_fetch_queue_mw_pkg::*;
#(
  parameter int FETCH_WIDTH     = 4,
  parameter int IFQ_ENTRY       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int META_WIDTH      = 64,
  localparam int LOG_FW         = clog2(FETCH_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      fa_valid,
  output logic                      fa_ready,
  input  logic [31:0]               fa_pc,
  input  logic [LOG_FW:0]           fa_cnt,
  input  logic [META_WIDTH-1:0]     fa_meta,
  output logic                      inst_addr_valid,
  input  logic                      inst_addr_ready,
  output logic [31:0]               inst_addr,
  input  logic                      inst_line_valid,
  output logic                      inst_line_ready,
  input  logic [32*FETCH_WIDTH-1:0] inst_line,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [31:0]               pc,
  output logic [29:0]               pc_4,
  output logic [META_WIDTH-1:0]     meta,
  output logic [4:0]                excep_code
);

  localparam int LOG_Q  = clog2(IFQ_ENTRY);
  localparam int QCNT_W = LOG_Q + 1;
  localparam int CNT_W  = LOG_FW + 1;
  localparam int OUT_W  = clog2(MAX_OUTSTANDING + 1);

  logic [LOG_Q-1:0]  wr_ptr, resp_ptr, rd_ptr;
  logic [QCNT_W-1:0] count;
  logic [OUT_W-1:0]  unanswered, stale;
  logic [LOG_FW-1:0] slot;
  logic [IFQ_ENTRY-1:0] line_vld, vld_set, vld_clr;

  logic              can_alloc, alloc_fire, line_wr, out_fire, last_beat, pop;
  logic [CNT_W-1:0]  room, eff_cnt;
  resp_kind_e        resp_kind;

  logic [31:0]               head_pc;
  logic [CNT_W-1:0]          head_cnt;
  logic [32*FETCH_WIDTH-1:0] head_line;
  logic                      head_misaligned;
  logic [LOG_FW-1:0]         word_idx;

  // ---------------- request side ----------------
  assign can_alloc = (count < QCNT_W'(IFQ_ENTRY)) &&
                     ((unanswered + stale) < OUT_W'(MAX_OUTSTANDING));

  // Held low during reset so nothing is offered while state is cleared.
  assign inst_addr_valid = fa_valid & can_alloc & ~flush & rst;
  assign fa_ready        = inst_addr_ready & can_alloc & ~flush & rst;
  assign alloc_fire      = fa_valid & fa_ready;
  assign inst_addr       = {fa_pc[31:2+LOG_FW], {(2+LOG_FW){1'b0}}};

  assign room = CNT_W'(FETCH_WIDTH) - CNT_W'(fa_pc[2+:LOG_FW]);

  // Clamp the group so it never runs past the end of its cache line.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives eff_cnt,
    // so no latch is inferred.
    eff_cnt = fa_cnt;
    if (fa_pc[1:0] != 2'b00 || fa_cnt == '0) begin
      eff_cnt = CNT_W'(1);
    end else if (fa_cnt > room) begin
      eff_cnt = room;
    end
  end

  // ---------------- response side ----------------
  assign inst_line_ready = 1'b1;

  // Classify the response: stale lines are owed to flushed groups.
  always_comb begin
    resp_kind = RESP_NONE;
    if (inst_line_valid) begin
      if (stale != '0)           resp_kind = RESP_DROP;
      else if (unanswered != '0) resp_kind = RESP_FILL;
    end
  end

  assign line_wr = (resp_kind == RESP_FILL) & ~flush;

  // ---------------- storage ----------------
  inst_fetch_queue_mw_fetch_group_ram #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .IFQ_ENTRY   (IFQ_ENTRY),
    .META_WIDTH  (META_WIDTH),
    .CNT_W       (CNT_W),
    .IDX_W       (LOG_Q)
  ) u_ram (
    .clk        (clk),
    .alloc_en   (alloc_fire),
    .alloc_idx  (wr_ptr),
    .alloc_pc   (fa_pc),
    .alloc_cnt  (eff_cnt),
    .alloc_meta (fa_meta),
    .line_en    (line_wr),
    .line_idx   (resp_ptr),
    .line_data  (inst_line),
    .rd_idx     (rd_ptr),
    .rd_pc      (head_pc),
    .rd_cnt     (head_cnt),
    .rd_meta    (meta),
    .rd_line    (head_line)
  );

  // ---------------- decode side ----------------
  assign inst_valid      = line_vld[rd_ptr] & ~flush;
  assign out_fire        = inst_valid & inst_ready;
  assign last_beat       = (CNT_W'(slot) == head_cnt - CNT_W'(1));
  assign pop             = out_fire & last_beat;
  assign head_misaligned = (head_pc[1:0] != 2'b00);
  assign word_idx        = head_pc[2+:LOG_FW] + slot;

  assign inst       = head_misaligned ? 32'h0 : head_line[int'(word_idx)*32 +: 32];
  assign pc         = head_pc + {{(30-LOG_FW){1'b0}}, slot, 2'b00};
  assign pc_4       = pc[31:2] + 30'd1;
  assign excep_code = head_misaligned ? ADEL : INVALID_EXCEP;

  // Per-entry line-valid set/clear requests for this cycle.
  always_comb begin
    vld_set = '0;
    vld_clr = '0;
    if (alloc_fire) vld_clr[wr_ptr]   = 1'b1;
    if (pop)        vld_clr[rd_ptr]   = 1'b1;
    if (line_wr)    vld_set[resp_ptr] = 1'b1;
  end

  // Pointer, occupancy, outstanding/stale and slot bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      resp_ptr   <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      unanswered <= '0;
      stale      <= '0;
      slot       <= '0;
      line_vld   <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      resp_ptr   <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      unanswered <= '0;
      stale      <= stale + unanswered - OUT_W'(resp_kind != RESP_NONE);
      slot       <= '0;
      line_vld   <= '0;
    end else begin
      if (alloc_fire) wr_ptr   <= wr_ptr + LOG_Q'(1);
      if (line_wr)    resp_ptr <= resp_ptr + LOG_Q'(1);
      if (pop)        rd_ptr   <= rd_ptr + LOG_Q'(1);
      count      <= count + QCNT_W'(alloc_fire) - QCNT_W'(pop);
      unanswered <= unanswered + OUT_W'(alloc_fire) - OUT_W'(line_wr);
      stale      <= stale - OUT_W'(resp_kind == RESP_DROP);
      if (pop)           slot <= '0;
      else if (out_fire) slot <= slot + LOG_FW'(1);
      line_vld   <= (line_vld & ~vld_clr) | vld_set;
    end
  end

endmodule
